// File: rtl/mul_hilo_seq.sv
// Sequencer around a combinational signed 32x32 multiplier: latches operands,
// waits SETTLE cycles, captures the product into HI/LO, and owns MTHI/MTLO.
module mul_hilo_seq #(
   parameter int unsigned SETTLE = 2
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   input  logic        flush,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [31:0] mul_lo,
   input  logic [31:0] mul_hi,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] mul_a_q, mul_a_d;
   logic [31:0] mul_b_q, mul_b_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mul_a_d = a_in;
               mul_b_d = b_in;
               cnt_d   = CNT_INIT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               hi_d    = mul_hi;
               lo_d    = mul_lo;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // The multiply owns HI/LO while in flight; MTHI/MTLO only land outside WAIT.
      if (state_q != S_WAIT) begin
         if (hi_we) hi_d = wr_data;
         if (lo_we) lo_d = wr_data;
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         mul_a_q <= 32'd0;
         mul_b_q <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign mul_a  = mul_a_q;
   assign mul_b  = mul_b_q;
   assign hi_out = hi_q;
   assign lo_out = lo_q;
   assign busy   = (state_q == S_WAIT) || (state_q == S_DONE);
   assign done   = (state_q == S_DONE);

endmodule

// File: doc/mul_hilo_seq.md
# mul_hilo_seq

Sequencing and result-capture stage placed directly downstream of the combinational signed 32x32 Booth multiplier. It latches the operands that drive the multiplier and holds them stable for a fixed settle window. It then captures the 64-bit product into the architectural HI/LO registers and reports completion with a start/busy/done handshake. It also provides the MTHI/MTLO write path and the MFHI/MFLO read path, and supports a pipeline flush.

## Interface
- `SETTLE`, default 2: number of cycles the multiplier inputs are held before capture; legal range 1..15.
- `clock` in 1: single rising-edge clock.
- `clear` in 1: asynchronous, active-low reset.
- `start` in 1: request a multiply; sampled only in IDLE.
- `a_in` in 32: multiplicand, signed two's complement.
- `b_in` in 32: multiplier, signed two's complement.
- `flush` in 1: synchronous abort of an in-flight multiply.
- `mul_a` out 32: registered operand A, driving the multiplier's A.
- `mul_b` out 32: registered operand B, driving the multiplier's B.
- `mul_lo` in 32: multiplier low product word.
- `mul_hi` in 32: multiplier high product word.
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wr_data` in 32: MTHI/MTLO data.
- `busy` out 1: high in WAIT and DONE.
- `done` out 1: one-cycle pulse, high in DONE.
- `hi_out` out 32: HI register (MFHI).
- `lo_out` out 32: LO register (MFLO).

## Operation
- States:
  - IDLE (reset).
  - WAIT: operands stable, counter running.
  - DONE: result valid, `done`=1.
- Counter `cnt` is 4 bits.
- IDLE, `start`=1 at an edge:
  - `mul_a`<=`a_in`, `mul_b`<=`b_in`.
  - `cnt`<=SETTLE-1.
  - Next state is WAIT.
- IDLE, `start`=0: operands hold their previous values.
- WAIT, `flush`=1: go to IDLE. No capture; HI/LO unchanged; `done` does not pulse.
- WAIT, `cnt`≠0: `cnt` decrements.
- WAIT, `cnt`=0: `hi_out`<=`mul_hi`, `lo_out`<=`mul_lo` (the full 64-bit signed product, no truncation or saturation); next state is DONE.
- DONE: unconditionally returns to IDLE after one cycle. `flush` in DONE has no effect, because the result is already committed.
- `start` in WAIT or DONE is ignored. It is not queued.
- `mul_a`/`mul_b` change only on an accepted start. They are stable across all of WAIT and DONE.
- MTHI/MTLO:
  - In IDLE or DONE, `hi_we`=1 writes `wr_data` to HI and `lo_we`=1 writes it to LO. Both may be asserted in the same cycle.
  - In WAIT, writes are ignored (the multiply owns HI/LO).
- Same edge as an IDLE `start` and a write: both take effect. The write lands in HI/LO and the operands latch.
- `hi_out`/`lo_out` are plain register outputs, readable in every state.
- Reset (`clear`=0, any time, including mid-WAIT):
  - state→IDLE, `cnt`=0.
  - `mul_a`=`mul_b`=0.
  - `hi_out`=`lo_out`=0.
  - `busy`=`done`=0.
  - An in-flight multiply is lost.

## Timing
- Start accepted at edge E0:
  - `busy` rises after E0.
  - WAIT occupies SETTLE cycles.
  - Capture occurs at edge E0+SETTLE.
  - `done` is high for the cycle between E0+SETTLE and E0+SETTLE+1.
  - The module is in IDLE after E0+SETTLE+1.
- Latency from start to valid HI/LO is SETTLE+1 edges. Throughput is one multiply per SETTLE+2 cycles.
- SETTLE=1: capture at E0+1, `done` in the next cycle.
- The multiplier path from `mul_a`/`mul_b` to `mul_hi`/`mul_lo` must meet SETTLE clock periods as a multicycle path.
- `busy` and `done` are decoded from registered state only (glitch-free).

## Test plan
- Reset check: assert `clear` low mid-simulation with nonzero HI/LO. Required: `hi_out`=`lo_out`=0, `mul_a`=`mul_b`=0, `busy`=`done`=0, all immediately (asynchronous).
- Basic multiply: SETTLE=2, start with `a_in`=7, `b_in`=9, multiplier model attached. Required: `done` high exactly 3 cycles after the start edge, `lo_out`=63, `hi_out`=0.
- Signed multiply: `a_in`=0x80000000, `b_in`=2. Required: `hi_out`=0xFFFFFFFF, `lo_out`=0x00000000. Also `a_in`=`b_in`=0xFFFFFFFF. Required: `hi_out`=0, `lo_out`=1.
- Flush: start with 5×5, then `flush`=1 in the first WAIT cycle. Required: back in IDLE next cycle, no `done`, HI/LO keep their prior values. A fresh start is accepted in the following cycle.
- Write arbitration: `hi_we`=1 with `wr_data`=0xDEADBEEF during WAIT is ignored, and HI receives the product. The same write in DONE sets `hi_out`=0xDEADBEEF; in IDLE also 0xDEADBEEF.
- Start during busy: pulse `start` with new operands during WAIT and DONE. Required: `mul_a`/`mul_b` unchanged, exactly one `done` pulse, and the result equals the first operand pair.
